way_hit_select: RTL and testbench

WAY_HIT_SELECT -- requirements
Module: way_hit_select

---
 rtl/way_hit_select.sv | 88 ++++++++
 tb/tb_way_hit_select.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/way_hit_select.sv
// Parallel tag compare across WAYS cache ways with a one-cycle registered hit, way select and line mux.
// Optional multi-hit detection is enabled by defining WAY_HIT_SELECT_MULTI_HIT_CHECK_EN.
module way_hit_select #(
  parameter int WAYS           = 4,
  parameter int TAG_BITS       = 18,
  parameter int LINE_SIZE_BITS = 512,
  parameter int IDX_BITS       = $clog2(WAYS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_req,
  input  logic [TAG_BITS-1:0]          i_tag,
  input  logic [WAYS*TAG_BITS-1:0]     i_way_tag,
  input  logic [WAYS-1:0]              i_way_valid,
  input  logic [WAYS*LINE_SIZE_BITS-1:0] i_way_data,
  output logic                         o_valid,
  output logic                         o_cache_hit,
  output logic [WAYS-1:0]              o_way_sel,
  output logic [IDX_BITS-1:0]          o_way_idx,
  output logic [LINE_SIZE_BITS-1:0]    o_data,
  output logic                         o_multi_hit
);

  logic [WAYS-1:0]           sel_raw;
  logic [WAYS-1:0]           sel_onehot;
  logic                      hit;
  logic [IDX_BITS-1:0]       idx_d;
  logic [LINE_SIZE_BITS-1:0] data_d;

  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    sel_raw = '0;
    for (int w = 0; w < WAYS; w++) begin
      sel_raw[w] = i_way_valid[w] && (i_way_tag[w*TAG_BITS +: TAG_BITS] == i_tag);
    end
  end

  // Two's-complement trick isolates the lowest set bit without a priority chain.
  assign sel_onehot = sel_raw & (~sel_raw + WAYS'(1));
  assign hit        = |sel_raw;

  // Because sel_onehot has at most one bit set, OR-ing masked terms is an exact mux and yields 0 on a miss.
  always_comb begin
    idx_d  = '0;
    data_d = '0;
    for (int w = 0; w < WAYS; w++) begin
      idx_d  = idx_d  | ({IDX_BITS{sel_onehot[w]}} & IDX_BITS'(w));
      data_d = data_d | ({LINE_SIZE_BITS{sel_onehot[w]}} & i_way_data[w*LINE_SIZE_BITS +: LINE_SIZE_BITS]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_valid     <= 1'b0;
      o_cache_hit <= 1'b0;
      o_way_sel   <= '0;
      o_way_idx   <= '0;
      o_data      <= '0;
    end else begin
      o_valid <= i_req;
      if (i_req) begin
        o_cache_hit <= hit;
        o_way_sel   <= sel_onehot;
        o_way_idx   <= idx_d;
        o_data      <= data_d;
      end
    end
  end

`ifdef WAY_HIT_SELECT_MULTI_HIT_CHECK_EN
  logic multi_hit_d;

  // Clearing the lowest set bit leaves something only when two or more ways hit.
  assign multi_hit_d = |(sel_raw & (sel_raw - WAYS'(1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_multi_hit <= 1'b0;
    end else if (i_req) begin
      o_multi_hit <= multi_hit_d;
    end
  end
`else
  assign o_multi_hit = 1'b0;
`endif

endmodule

// File: tb/tb_way_hit_select.sv
// Directed self-checking bench for way_hit_select at default parameters (4 ways, 18-bit tags, 512-bit lines).
module tb_way_hit_select;

  localparam int WAYS = 4;
  localparam int TB   = 18;
  localparam int LB   = 512;
  localparam int IB   = 2;

  logic              clk;
  logic              rst;
  logic              i_req;
  logic [TB-1:0]     i_tag;
  logic [WAYS*TB-1:0] i_way_tag;
  logic [WAYS-1:0]   i_way_valid;
  logic [WAYS*LB-1:0] i_way_data;
  logic              o_valid;
  logic              o_cache_hit;
  logic [WAYS-1:0]   o_way_sel;
  logic [IB-1:0]     o_way_idx;
  logic [LB-1:0]     o_data;
  logic              o_multi_hit;

  int total = 0;
  int bad   = 0;

  logic [LB-1:0] line0, line1, line2, line3;
  logic          exp_multi;

  way_hit_select #(.WAYS(WAYS), .TAG_BITS(TB), .LINE_SIZE_BITS(LB)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_tag(i_tag),
    .i_way_tag(i_way_tag), .i_way_valid(i_way_valid), .i_way_data(i_way_data),
    .o_valid(o_valid), .o_cache_hit(o_cache_hit), .o_way_sel(o_way_sel),
    .o_way_idx(o_way_idx), .o_data(o_data), .o_multi_hit(o_multi_hit)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_ways(input logic [TB-1:0] t0, input logic [TB-1:0] t1,
                          input logic [TB-1:0] t2, input logic [TB-1:0] t3,
                          input logic [WAYS-1:0] vld);
    i_way_tag   = {t3, t2, t1, t0};
    i_way_valid = vld;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef WAY_HIT_SELECT_MULTI_HIT_CHECK_EN
    exp_multi = 1'b1;
`else
    exp_multi = 1'b0;
`endif
    line0 = {16{32'hDEAD_BE00}};
    line1 = {16{32'hDEAD_BE01}};
    line2 = {16{32'hDEAD_BE02}};
    line3 = {16{32'hDEAD_BE03}};
    i_way_data = {line3, line2, line1, line0};
    rst   = 1'b0;
    i_req = 1'b0;
    i_tag = 18'h2A5F3;
    set_ways(18'h00001, 18'h00002, 18'h00003, 18'h00004, 4'b1111);

    // Reset state before any clock edge.
    #2;
    check("rst_valid", LB'(o_valid), LB'(0));
    check("rst_hit",   LB'(o_cache_hit), LB'(0));
    check("rst_sel",   LB'(o_way_sel), LB'(0));
    check("rst_idx",   LB'(o_way_idx), LB'(0));
    check("rst_data",  o_data, LB'(0));
    check("rst_multi", LB'(o_multi_hit), LB'(0));

    // Release with no request: no result pulse.
    @(negedge clk); rst = 1'b1;
    step();
    check("idle_valid", LB'(o_valid), LB'(0));

    // Single hit on way 2.
    @(negedge clk);
    set_ways(18'h00001, 18'h00002, 18'h2A5F3, 18'h00004, 4'b1111);
    i_req = 1'b1;
    step();
    check("hit2_valid", LB'(o_valid), LB'(1));
    check("hit2_hit",   LB'(o_cache_hit), LB'(1));
    check("hit2_sel",   LB'(o_way_sel), LB'(4'b0100));
    check("hit2_idx",   LB'(o_way_idx), LB'(2));
    check("hit2_data",  o_data, line2);
    check("hit2_multi", LB'(o_multi_hit), LB'(0));

    // No request: pulse drops, result holds even though inputs change to a miss.
    @(negedge clk);
    i_req = 1'b0;
    set_ways(18'h00001, 18'h00002, 18'h00003, 18'h00004, 4'b1111);
    step();
    check("hold_valid", LB'(o_valid), LB'(0));
    check("hold_hit",   LB'(o_cache_hit), LB'(1));
    check("hold_idx",   LB'(o_way_idx), LB'(2));
    check("hold_data",  o_data, line2);

    // Matching tag on an invalid way never hits.
    @(negedge clk);
    set_ways(18'h00001, 18'h2A5F3, 18'h00003, 18'h00004, 4'b1101);
    i_req = 1'b1;
    step();
    check("inv_valid", LB'(o_valid), LB'(1));
    check("inv_hit",   LB'(o_cache_hit), LB'(0));
    check("inv_sel",   LB'(o_way_sel), LB'(0));
    check("inv_idx",   LB'(o_way_idx), LB'(0));
    check("inv_data",  o_data, LB'(0));

    // Single hit on the top way exercises the high index bit.
    @(negedge clk);
    set_ways(18'h00001, 18'h00002, 18'h00003, 18'h2A5F3, 4'b1111);
    step();
    check("hit3_sel",  LB'(o_way_sel), LB'(4'b1000));
    check("hit3_idx",  LB'(o_way_idx), LB'(3));
    check("hit3_data", o_data, line3);

    // Tag differing only in the LSB is a miss.
    @(negedge clk);
    set_ways(18'h2A5F2, 18'h00002, 18'h00003, 18'h00004, 4'b1111);
    step();
    check("lsb_hit",  LB'(o_cache_hit), LB'(0));
    check("lsb_data", o_data, LB'(0));

    // Multi-hit on ways 1 and 3 returns the lower way.
    @(negedge clk);
    set_ways(18'h00001, 18'h2A5F3, 18'h00003, 18'h2A5F3, 4'b1111);
    step();
    check("multi_hit",  LB'(o_cache_hit), LB'(1));
    check("multi_sel",  LB'(o_way_sel), LB'(4'b0010));
    check("multi_idx",  LB'(o_way_idx), LB'(1));
    check("multi_data", o_data, line1);
    check("multi_flag", LB'(o_multi_hit), LB'(exp_multi));

    // Back-to-back: hit on way 0, then a miss, then idle.
    @(negedge clk);
    set_ways(18'h2A5F3, 18'h00002, 18'h00003, 18'h00004, 4'b1111);
    step();
    check("b2b0_valid", LB'(o_valid), LB'(1));
    check("b2b0_sel",   LB'(o_way_sel), LB'(4'b0001));
    check("b2b0_idx",   LB'(o_way_idx), LB'(0));
    check("b2b0_data",  o_data, line0);
    check("b2b0_multi", LB'(o_multi_hit), LB'(0));
    @(negedge clk);
    set_ways(18'h00001, 18'h00002, 18'h00003, 18'h00004, 4'b1111);
    step();
    check("b2b1_valid", LB'(o_valid), LB'(1));
    check("b2b1_hit",   LB'(o_cache_hit), LB'(0));
    check("b2b1_data",  o_data, LB'(0));
    @(negedge clk);
    i_req = 1'b0;
    step();
    check("b2b2_valid", LB'(o_valid), LB'(0));
    check("b2b2_hit",   LB'(o_cache_hit), LB'(0));
    check("b2b2_sel",   LB'(o_way_sel), LB'(0));

    // Reset mid-operation: result is cleared at once and no pulse follows.
    @(negedge clk);
    set_ways(18'h00001, 18'h00002, 18'h2A5F3, 18'h00004, 4'b1111);
    i_req = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    i_req = 1'b0;
    #1;
    check("mid_valid", LB'(o_valid), LB'(0));
    check("mid_hit",   LB'(o_cache_hit), LB'(0));
    check("mid_data",  o_data, LB'(0));
    check("mid_idx",   LB'(o_way_idx), LB'(0));
    @(negedge clk); rst = 1'b1;
    step();
    check("mid_after_valid", LB'(o_valid), LB'(0));
    check("mid_after_data",  o_data, LB'(0));

    // Request present while reset releases is served on the next edge.
    @(negedge clk); rst = 1'b0;
    i_req = 1'b1;
    @(negedge clk); rst = 1'b1;
    step();
    check("rel_valid", LB'(o_valid), LB'(1));
    check("rel_idx",   LB'(o_way_idx), LB'(2));
    check("rel_data",  o_data, line2);

    @(negedge clk);
    i_req = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
